// File: rtl/invsqrt_arbiter.sv
// Round-robin front end that shares one fixed-latency inverse-sqrt pipeline among
// N_REQ requesters. A tag shift register tracks each operation so its result returns to the right requester.
module invsqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 10,
  parameter int DATA_W  = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        res_valid,
  output logic [DATA_W-1:0]       res_data,
  input  logic [N_REQ-1:0]        res_ready,
  output logic                    pipe_ce,
  output logic [DATA_W-1:0]       pipe_in,
  input  logic [DATA_W-1:0]       pipe_out,
  input  logic                    pipe_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshakes: an operand moves on an edge where req_valid[i] && req_ready[i];
  // a result moves on an edge where res_valid[i] && res_ready[i]. Neither valid
  // may depend on its ready; req_ready depends on req_valid.

  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic               tail_v;
  logic [ID_W-1:0]    tail_id;
  logic               stall;
  logic               grant_en;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  int                 scan_idx;

  assign tail_v   = tag_v[LATENCY-1];
  assign tail_id  = tag_id[LATENCY-1];
  assign stall    = tail_v && !res_ready[tail_id];
  assign grant_en = !rst && !stall;
  assign busy     = |tag_v;
  assign pipe_ce  = grant_en && ((|req_valid) || busy);
  assign res_data = pipe_out;

  // Scan requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!grant_found && grant_en && req_valid[ID_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    pipe_in   = '0;
    if (grant_found) begin
      req_ready[grant_id] = 1'b1;
      pipe_in             = req_data[int'(grant_id)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    res_valid = '0;
    if (tail_v) begin
      res_valid[tail_id] = 1'b1;
    end
  end

  always_comb begin
    rr_next = '0;
    if (int'(grant_id) != N_REQ - 1) begin
      rr_next = grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (pipe_ce) begin
        tag_v[0] <= grant_found;
        for (int k = 1; k < LATENCY; k++) begin
          tag_v[k] <= tag_v[k-1];
        end
      end
      if (grant_found) begin
        rr_ptr <= rr_next;
      end
      // A tracked result reaching the tail without pipeline valid means the
      // pipeline depth does not match LATENCY.
      if (tail_v && !pipe_ready) begin
        err <= 1'b1;
      end
    end
  end

  // Ids need no reset: they are only looked at behind a set valid bit.
  always_ff @(posedge clk) begin
    if (pipe_ce) begin
      tag_id[0] <= grant_found ? grant_id : '0;
      for (int k = 1; k < LATENCY; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Directed bench for invsqrt_arbiter with a behavioural fixed-latency pipeline
// whose result table holds hand-computed 1/sqrt values.
module tb_invsqrt_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 10;
  localparam int DW    = 31;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*DW-1:0]  req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     res_valid;
  logic [DW-1:0]        res_data;
  logic [N_REQ-1:0]     res_ready;
  logic                 pipe_ce;
  logic [DW-1:0]        pipe_in;
  logic [DW-1:0]        pipe_out;
  logic                 pipe_ready;
  logic                 busy;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  invsqrt_arbiter #(.N_REQ(N_REQ), .LATENCY(LAT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .pipe_ce(pipe_ce), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .pipe_ready(pipe_ready), .busy(busy), .err(err)
  );

  // External pipeline: LAT ce-enabled stages, result looked up at the output.
  logic [DW-1:0] pstage [LAT];

  always @(posedge clk) begin
    if (pipe_ce) begin
      for (int k = LAT - 1; k > 0; k--) pstage[k] <= pstage[k-1];
      pstage[0] <= pipe_in;
    end
  end

  function automatic logic [DW-1:0] model_rsqrt(input logic [DW-1:0] x);
    case (x)
      31'h3E000000: return 31'h403504F3;  // 0.125 -> 2.828427
      31'h3E800000: return 31'h40000000;  // 0.25  -> 2.0
      31'h3F800000: return 31'h3F800000;  // 1.0   -> 1.0
      31'h40800000: return 31'h3F000000;  // 4.0   -> 0.5
      default:      return x;             // tagging operands come back unchanged
    endcase
  endfunction

  assign pipe_out = model_rsqrt(pstage[LAT-1]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    res_ready  = '1;
    pipe_ready = 1'b1;

    // Reset: outputs quiet even with every requester asking.
    tick();
    tick();
    req_valid = 4'b1111;
    settle();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_pipe_ce",   32'(pipe_ce),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_pipe_in",   32'(pipe_in),   32'd0);
    req_valid = '0;
    rst = 1'b0;
    settle();
    check("idle_pipe_in", 32'(pipe_in), 32'd0);

    // Single op from requester 2: result exactly LAT cycles after grant.
    drive(2, 1'b1, 31'h3E000000);
    settle();
    check("t1_grant",   32'(req_ready), 32'h4);
    check("t1_pipe_in", 32'(pipe_in),   32'h3E000000);
    check("t1_pipe_ce", 32'(pipe_ce),   32'd1);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1) drive(2, 1'b0, '0);
      settle();
      check("t1_busy",      32'(busy),      32'd1);
      check("t1_res_valid", 32'(res_valid), (k == LAT) ? 32'h4 : 32'h0);
    end
    check("t1_res_data", 32'(res_data), 32'h403504F3);
    tick();
    check("t1_res_done",  32'(res_valid), 32'd0);
    check("t1_busy_done", 32'(busy),      32'd0);

    // Round robin: all four valid straight out of reset.
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, DW'(32'h1000 + i));
    tick();
    rst = 1'b0;
    settle();
    for (int c = 0; c < 16; c++) begin
      check("rr_grant",   32'(req_ready), 32'(1 << (c % 4)));
      check("rr_pipe_ce", 32'(pipe_ce),   32'd1);
      if (c >= LAT) begin
        check("rr_res_valid", 32'(res_valid), 32'(1 << ((c - LAT) % 4)));
        check("rr_res_data",  32'(res_data),  32'h1000 + 32'((c - LAT) % 4));
      end
      tick();
    end

    // Backpressure on requester 1 while its result sits at the tail.
    do_reset();
    res_ready = 4'b1101;
    drive(1, 1'b1, 31'h3E800000);
    settle();
    check("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    drive(1, 1'b0, '0);
    drive(3, 1'b1, 31'h40800000);
    settle();
    check("bp_grant3", 32'(req_ready), 32'h8);
    repeat (LAT - 1) tick();
    for (int s = 0; s < 5; s++) begin
      check("bp_stall_ce",    32'(pipe_ce),   32'd0);
      check("bp_stall_ready", 32'(req_ready), 32'd0);
      check("bp_stall_valid", 32'(res_valid), 32'h2);
      check("bp_stall_data",  32'(res_data),  32'h40000000);
      tick();
    end
    res_ready = 4'b1111;
    settle();
    check("bp_release_valid", 32'(res_valid), 32'h2);
    check("bp_release_data",  32'(res_data),  32'h40000000);
    check("bp_release_ce",    32'(pipe_ce),   32'd1);
    check("bp_release_grant", 32'(req_ready), 32'h8);
    for (int c = 16; c <= 25; c++) begin
      tick();
      check("bp_resume_valid", 32'(res_valid), 32'h8);
      check("bp_resume_data",  32'(res_data),  32'h3F000000);
    end
    drive(3, 1'b0, '0);
    check("bp_err", 32'(err), 32'd0);

    // Steady stream of 1.0 from requesters 0 and 2: retire and grant overlap.
    do_reset();
    drive(0, 1'b1, 31'h3F800000);
    drive(2, 1'b1, 31'h3F800000);
    settle();
    for (int c = 0; c < 20; c++) begin
      check("ss_grant",   32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
      check("ss_pipe_ce", 32'(pipe_ce),   32'd1);
      if (c >= LAT) begin
        check("ss_res_valid", 32'(res_valid), ((c - LAT) % 2 == 0) ? 32'h1 : 32'h4);
        check("ss_res_data",  32'(res_data),  32'h3F800000);
      end
      tick();
    end
    drive(0, 1'b0, '0);
    drive(2, 1'b0, '0);

    // Reset with six operations in flight.
    do_reset();
    for (int i = 0; i < N_REQ; i++) drive(i, 1'b1, DW'(32'h2000 + i));
    settle();
    for (int c = 0; c < 6; c++) begin
      check("mr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      tick();
    end
    req_valid = '0;
    settle();
    check("mr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mr_busy_after", 32'(busy), 32'd0);
    check("mr_err_after",  32'(err),  32'd0);
    for (int c = 0; c < 12; c++) begin
      check("mr_no_result", 32'(res_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    settle();
    check("mr_first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Pipeline valid missing while a tail tag is valid: sticky error.
    do_reset();
    drive(0, 1'b1, 31'h3F800000);
    settle();
    check("er_err_idle", 32'(err), 32'd0);
    tick();
    drive(0, 1'b0, '0);
    repeat (LAT - 1) tick();
    check("er_tail_valid", 32'(res_valid), 32'h1);
    check("er_err_before", 32'(err),       32'd0);
    pipe_ready = 1'b0;
    tick();
    pipe_ready = 1'b1;
    settle();
    check("er_err_set", 32'(err),  32'd1);
    check("er_retired", 32'(busy), 32'd0);
    repeat (3) tick();
    check("er_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("er_err_cleared", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/invsqrt_arbiter.md
INVSQRT_ARBITER -- requirements
Module: invsqrt_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one invsqrt_pipeline instance.
REQ-002 Parameter LATENCY, default 10: pipeline depth in ce-enabled clock edges from operand capture to valid pipe_out.
REQ-003 Parameter DATA_W, default 31: operand/result width, an IEEE-754 single without sign bit.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester operand valid.
REQ-007 req_data  in  N_REQ*DATA_W  per-requester operand; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  out  N_REQ  grant; one-hot or zero.
REQ-009 res_valid  out  N_REQ  result valid for requester i; one-hot or zero.
REQ-010 res_data  out  DATA_W  shared result bus, meaningful only while some res_valid bit is 1.
REQ-011 res_ready  in  N_REQ  per-requester result acceptance.
REQ-012 pipe_ce  out  1  clock enable to the pipeline.
REQ-013 pipe_in  out  DATA_W  operand to the pipeline.
REQ-014 pipe_out  in  DATA_W  pipeline result.
REQ-015 pipe_ready  in  1  pipeline output-valid flag.
REQ-016 busy  out  1  at least one operation in flight.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 The block SHALL keep a tag shift register of LATENCY stages, each {valid, id[clog2(N_REQ)-1:0]}; the tail is stage LATENCY-1.
REQ-019 The tag register SHALL advance only on edges where pipe_ce=1; stage 0 loads {1, grant id} on a grant, else {0, x}.
REQ-020 stall SHALL be defined as tail.valid && !res_ready[tail.id].
REQ-021 pipe_ce SHALL equal !stall && (|req_valid || any tag valid).
REQ-022 Under stall: pipe_ce=0, req_ready=0, tags hold, res_valid held asserted with stable res_data.
REQ-023 Grant (combinational): when !stall, the first requester with req_valid=1 in round-robin order starting at rr_ptr SHALL receive req_ready=1; no other requester receives it.
REQ-024 On a transfer (req_valid[g] && req_ready[g]), rr_ptr SHALL become (g+1) mod N_REQ; otherwise rr_ptr holds.
REQ-025 pipe_in SHALL equal req_data of the granted requester, and 0 when no grant.
REQ-026 res_valid[i] SHALL equal tail.valid && tail.id==i; res_data SHALL equal pipe_out.
REQ-027 A result transfers when res_valid[i] && res_ready[i]; the same edge advances the pipeline, so throughput is 1 op/cycle.
REQ-028 A result retire and a new grant in the same cycle SHALL both be allowed.
REQ-029 Results SHALL return in issue order; per-requester order is therefore preserved.
REQ-030 Grant-to-result latency SHALL be exactly LATENCY cycles when no stall occurs; each stall cycle adds one cycle.
REQ-031 busy SHALL equal OR of all tag valid bits.
REQ-032 err SHALL be set on any edge where tail.valid=1 and pipe_ready=0; it SHALL be cleared only by rst.
REQ-033 Operands SHALL be forwarded unchecked; zero, denormal, inf and NaN inputs are passed to the pipeline as-is.

Reset
REQ-034 While rst=1 at posedge clk: all tag valid bits SHALL be cleared, rr_ptr=0, and err=0.
REQ-035 During and after reset: req_ready=0, res_valid=0, pipe_ce=0, busy=0, and pipe_in=0 until the first request.
REQ-036 Reset mid-operation SHALL discard all in-flight results; none appear on res_valid afterwards.
REQ-037 Pipeline contents are not reset; stale data are masked by the cleared tags.

Verification
REQ-038 Single op: requester 2 sends 0x3E000000 (0.125) -> res_valid[2] exactly 10 cycles after grant, res_data about 0x403504F3 (2.828427, within pipeline accuracy); busy high for those 10 cycles.
REQ-039 Round-robin: all 4 requesters valid continuously from reset -> grants 0,1,2,3,0,...; each result routed to its own id; 1 result/cycle.
REQ-040 Backpressure: res_ready[1]=0 for 5 cycles while its result 0x40000000 (from 0.25) is at the tail -> pipe_ce=0, req_ready=0, res_data stable for 5 cycles; then transfer and resumption with no result lost or duplicated.
REQ-041 Simultaneous retire and grant: a steady stream of 1.0 (0x3F800000) -> every output equals 0x3F800000; no bubble inserted.
REQ-042 Reset mid-flight: 6 ops outstanding, assert rst for 1 cycle -> no res_valid afterwards, busy=0, err=0, rr_ptr=0 (requester 0 granted first).
REQ-043 Error: force pipe_ready=0 while a tail tag is valid -> err=1 and it stays 1 until rst.
